// File: rtl/mlsdot_update_sched.sv
// Programmed-loop sequencer for the MAC&LOAD address-update requests:
// per iteration it issues wpa weight-buffer updates, then one activation-buffer update.
module mlsdot_update_sched #(
   parameter int unsigned ITER_W = 16,
   parameter int unsigned WPA_W  = 8
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              stall_i,
   input  logic [ITER_W-1:0] cfg_iters_i,
   input  logic [WPA_W-1:0]  cfg_wpa_i,
   output logic              update_a_o,
   output logic              update_w_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [ITER_W-1:0] iter_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE_W = 2'd1,
      ST_ISSUE_A = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [ITER_W-1:0] iters_q, iters_d;
   logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
   logic [WPA_W-1:0]  wpa_q, wpa_d;
   logic [WPA_W-1:0]  w_cnt_q, w_cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ITER_W-1:0] iter_nxt;
   logic [WPA_W-1:0]  w_nxt;

   assign iter_nxt = iter_cnt_q + ITER_W'(1);
   assign w_nxt    = w_cnt_q + WPA_W'(1);

   // Next-state, counter and config-latch logic; abort overrides everything below reset
   always_comb begin
      state_d    = state_q;
      iters_d    = iters_q;
      wpa_d      = wpa_q;
      w_cnt_d    = w_cnt_q;
      iter_cnt_d = iter_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               iters_d    = cfg_iters_i;
               wpa_d      = cfg_wpa_i;
               w_cnt_d    = '0;
               iter_cnt_d = '0;
               if (cfg_iters_i == '0) begin
                  state_d = ST_DONE;
               end else if (cfg_wpa_i == '0) begin
                  state_d = ST_ISSUE_A;
               end else begin
                  state_d = ST_ISSUE_W;
               end
            end
         end
         ST_ISSUE_W: begin
            if (!stall_i) begin
               if (w_nxt == wpa_q) begin
                  w_cnt_d = '0;
                  state_d = ST_ISSUE_A;
               end else begin
                  w_cnt_d = w_nxt;
               end
            end
         end
         ST_ISSUE_A: begin
            if (!stall_i) begin
               iter_cnt_d = iter_nxt;
               if (iter_nxt == iters_q) begin
                  state_d = ST_DONE;
               end else if (wpa_q == '0) begin
                  state_d = ST_ISSUE_A;
               end else begin
                  state_d = ST_ISSUE_W;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (abort_i) begin
         state_d    = ST_IDLE;
         w_cnt_d    = '0;
         iter_cnt_d = iter_cnt_q;
         iters_d    = iters_q;
         wpa_d      = wpa_q;
      end

      busy_d = (state_d == ST_ISSUE_W) || (state_d == ST_ISSUE_A);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q    <= ST_IDLE;
         iters_q    <= '0;
         wpa_q      <= '0;
         w_cnt_q    <= '0;
         iter_cnt_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         iters_q    <= iters_d;
         wpa_q      <= wpa_d;
         w_cnt_q    <= w_cnt_d;
         iter_cnt_q <= iter_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Requests are decoded from state so a stall cycle produces no pulse and loses nothing
   assign update_w_o = (state_q == ST_ISSUE_W) && !stall_i && !abort_i;
   assign update_a_o = (state_q == ST_ISSUE_A) && !stall_i && !abort_i;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign iter_cnt_o = iter_cnt_q;

endmodule

// File: tb/tb_mlsdot_update_sched.sv
// Scoreboard bench for mlsdot_update_sched: the driver pushes the expected W/A/D event
// stream of each run, a negedge monitor pops and compares every observed event.
module tb_mlsdot_update_sched;

   localparam int unsigned ITER_W = 16;
   localparam int unsigned WPA_W  = 8;
   localparam int EV_W    = 0;
   localparam int EV_A    = 1;
   localparam int EV_D    = 2;
   localparam int EV_NONE = 3;

   logic              clk_i = 1'b0;
   logic              rstn_i;
   logic              start_i;
   logic              abort_i;
   logic              stall_i;
   logic [ITER_W-1:0] cfg_iters_i;
   logic [WPA_W-1:0]  cfg_wpa_i;
   logic              update_a_o;
   logic              update_w_o;
   logic              busy_o;
   logic              done_o;
   logic [ITER_W-1:0] iter_cnt_o;

   int errors = 0;
   int checks = 0;
   int exp_q[$];
   bit mon_en = 1'b0;

   mlsdot_update_sched #(.ITER_W(ITER_W), .WPA_W(WPA_W)) dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .stall_i     (stall_i),
      .cfg_iters_i (cfg_iters_i),
      .cfg_wpa_i   (cfg_wpa_i),
      .update_a_o  (update_a_o),
      .update_w_o  (update_w_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .iter_cnt_o  (iter_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pop_exp();
      if (exp_q.size() == 0) return EV_NONE;
      return exp_q.pop_front();
   endfunction

   // Monitor: every observed request or done pulse must be the next expected event
   always @(negedge clk_i) begin
      if (mon_en) begin
         check("mutex", 32'(update_a_o & update_w_o), 32'd0);
         if (update_w_o === 1'b1) check("seq_w", 32'(EV_W), 32'(pop_exp()));
         if (update_a_o === 1'b1) check("seq_a", 32'(EV_A), 32'(pop_exp()));
         if (done_o === 1'b1)     check("seq_done", 32'(EV_D), 32'(pop_exp()));
      end
   end

   // One run: iterations x (wpa W then one A), then done; optional kill by abort or reset
   task automatic run(input int iters, input int wpa, input int stall_mode,
                      input int abort_after, input int rst_after, input bit rand_start);
      int  total, lim, remaining, emitted, cyc, exp_iter;
      bit  killed, finished, by_rst;
      total = iters * (wpa + 1);
      lim = total;
      if (abort_after >= 0 && abort_after < total) lim = abort_after;
      if (rst_after >= 0 && rst_after < total) lim = rst_after;
      for (int k = 0; k < lim; k++) exp_q.push_back(((k % (wpa + 1)) == wpa) ? EV_A : EV_W);
      if (lim == total) exp_q.push_back(EV_D);

      @(posedge clk_i); #1;
      start_i = 1'b1; cfg_iters_i = ITER_W'(iters); cfg_wpa_i = WPA_W'(wpa); stall_i = 1'b0;
      @(posedge clk_i); #1;
      start_i = 1'b0; cfg_iters_i = ITER_W'($urandom); cfg_wpa_i = WPA_W'($urandom);

      remaining = total; emitted = 0; killed = 0; finished = 0; by_rst = 0; cyc = 1;
      while (!killed && !finished && cyc < total * 4 + 50) begin
         case (stall_mode)
            1:       stall_i = ($urandom_range(0, 3) == 0);
            2:       stall_i = (cyc >= 2 && cyc <= 4);
            default: stall_i = 1'b0;
         endcase
         start_i = rand_start && (remaining > 0) && ($urandom_range(0, 2) == 0);
         cfg_iters_i = ITER_W'($urandom_range(0, 7));
         cfg_wpa_i = WPA_W'($urandom_range(0, 7));
         if (remaining > 0 && emitted == abort_after) begin
            abort_i = 1'b1; killed = 1;
         end else if (remaining > 0 && emitted == rst_after) begin
            rstn_i = 1'b0; stall_i = 1'b1; killed = 1; by_rst = 1;
         end
         @(negedge clk_i);
         if (!killed) begin
            check("busy", 32'(busy_o), 32'(remaining > 0));
            if (remaining == 0) begin
               check("done", 32'(done_o), 32'd1);
               finished = 1;
            end else begin
               check("done_early", 32'(done_o), 32'd0);
               if (!stall_i) begin
                  remaining--; emitted++;
               end
               @(posedge clk_i); #1;
               cyc++;
            end
         end
      end

      @(posedge clk_i); #1;
      start_i = 1'b0; stall_i = 1'b0; abort_i = 1'b0; rstn_i = 1'b1;
      if (!killed && !finished) check("timeout", 32'd1, 32'd0);
      exp_iter = by_rst ? 0 : (killed ? emitted / (wpa + 1) : iters);
      check("idle_busy", 32'(busy_o), 32'd0);
      check("idle_done", 32'(done_o), 32'd0);
      check("idle_upd", 32'({update_a_o, update_w_o}), 32'd0);
      check("iter_cnt", 32'(iter_cnt_o), 32'(exp_iter));
      check("leftover", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int it, wp, ab;
      rstn_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; stall_i = 1'b0;
      cfg_iters_i = '0; cfg_wpa_i = '0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_upd", 32'({update_a_o, update_w_o}), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_iter", 32'(iter_cnt_o), 32'd0);
      #1 rstn_i = 1'b1;
      mon_en = 1'b1;

      run(2, 3, 0, -1, -1, 0);     // basic
      run(1, 2, 2, -1, -1, 0);     // 3-cycle stall after first W
      run(0, 5, 0, -1, -1, 0);     // zero iterations
      run(3, 0, 0, -1, -1, 0);     // zero weights per iteration
      run(4, 1, 0, 3, -1, 0);      // abort after 3rd pulse
      run(1, 1, 0, -1, -1, 0);     // restart after abort
      run(3, 2, 0, -1, -1, 1);     // start pulses while busy
      run(5, 2, 1, -1, 4, 0);      // reset mid-run
      run(2, 2, 0, -1, -1, 0);     // restart after reset
      run(1, 255, 0, -1, -1, 0);   // max weights per iteration
      run(300, 0, 1, -1, -1, 1);

      for (int n = 0; n < 40; n++) begin
         it = $urandom_range(0, 20);
         wp = $urandom_range(0, 8);
         ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, it * (wp + 1)) : -1;
         run(it, wp, 1, ab, -1, 1);
         repeat ($urandom_range(0, 2)) @(posedge clk_i);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
